branch_history_queue: RTL and testbench
=======================================

# branch_history_queue

Tracks every in-flight conditional branch from prediction to resolution, and is the write-side partner of the gshare branch history table. It maintains the speculative global branch history register (BHR) that indexes predictor reads, snapshots it per branch, and repairs it on a mispredict. It drains resolved branches in program order, issuing one registered training write per cycle to the table. It sits between fetch (allocation), the branch unit (resolution) and the predictor (read index and training write).

## Interface
- DEPTH, `BRANCH_HISTORY_TABLE_SIZE, predictor table entries; BHR_W = $clog2(DEPTH)
- QUEUE_DEPTH, 8, in-flight branch entries (power of two); TAG_W = $clog2(QUEUE_DEPTH)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- pred_valid  in  1  fetch presents a predicted conditional branch
- pred_pc  in  ADDR  branch PC
- pred_taken  in  1  direction supplied by the predictor
- pred_ready  out  1  space available (combinational: count < QUEUE_DEPTH)
- pred_tag  out  TAG_W  tag assigned to the branch accepted this cycle (= tail)
- rd_bhr  out  BHR_W  current speculative BHR, to predictor read index
- resolve_valid  in  1  branch unit resolves a branch
- resolve_tag  in  TAG_W  tag of the resolving branch
- resolve_taken  in  1  actual direction
- mispredict  out  1  registered pulse: the previous cycle's resolve disagreed with the stored prediction
- wr_en  out  1  registered predictor training write
- wr_taken  out  1  actual outcome
- wr_pc  out  ADDR  PC of the trained branch
- wr_bhr  out  BHR_W  BHR snapshot taken at prediction time

## Operation
- Entry fields: valid, resolved, pc, bhr (snapshot before shift), pred_taken, actual_taken. Pointers head/tail are TAG_W wide and wrap modulo QUEUE_DEPTH; count is TAG_W+1 bits.
- Allocate when pred_valid && pred_ready. Write the entry at tail with bhr = current BHR. Increment tail; shift BHR to {BHR[BHR_W-2:0], pred_taken}.
- Resolve when resolve_valid and entry[resolve_tag].valid; a resolve to an invalid tag is ignored. The branch unit never resolves the same tag twice. Set resolved and actual_taken.
  - If actual_taken != pred_taken: set BHR = {entry.bhr[BHR_W-2:0], resolve_taken}; set tail = resolve_tag+1; invalidate every younger entry; recompute count; pulse mispredict next cycle.
- Mispredict repair has priority over a same-cycle allocation. The allocation is dropped and fetch must re-present it; pred_ready stays as computed.
- Drain: each cycle, if entry[head] is valid && resolved, pop it. Load wr_en=1, wr_taken, wr_pc, wr_bhr from it into the output registers and advance head. Otherwise wr_en=0 next cycle.
- Simultaneous pop and allocate: count unchanged. Simultaneous pop and squash: the pop proceeds. The squashed range never includes head, because the mispredicting entry is retained.
- Full (count == QUEUE_DEPTH): pred_ready=0 and allocation is ignored. Empty: no write.

## Timing
- Reset values: pred_ready=1, pred_tag=0, rd_bhr=0, mispredict=0, wr_en=0, wr_taken=0, wr_pc=0, wr_bhr=0. head=tail=count=0, all entries invalid.
- Reset asserted mid-operation discards all entries and history asynchronously. No training write is issued for the discarded branches.
- rd_bhr reflects an allocation or repair from cycle N in cycle N+1.
- Resolve in cycle N at the head → wr_en high in cycle N+2 (marked N, popped N+1, registered out).
- Throughput: one allocation, one resolve and one training write per cycle.

## Configuration
- BHQ_SPEC_HISTORY_EN defined: BHR shifts speculatively at allocation and is repaired on mispredict, as above.
- Undefined: BHR shifts only at pop, with the actual outcome, so rd_bhr is committed history. The per-entry snapshot is still stored and sent on wr_bhr. Mispredict still squashes younger entries and pulses mispredict but does not modify BHR.

## Structure
- Shared package / sys_defs.svh: BHQ_ENTRY struct, BHQ_TAG typedef, QUEUE_DEPTH default macro.
- No sub-module. Entry storage is a flat array of BHQ_ENTRY with head/tail/count logic; the predictor stays a separate instance connected at the top level.

## Test plan
All scenarios use DEPTH=16 (BHR_W=4) and QUEUE_DEPTH=4.
- Reset: with reset low, all outputs are at their reset values. After reset rises, allocate pc=0x100 taken → pred_tag=0, rd_bhr=4'b0001 next cycle.
- Fill: allocate 4 branches → pred_ready=0. A fifth pred_valid is ignored and tail is unchanged. Resolve tag 0 → two cycles later wr_en=1, wr_pc=0x100, and pred_ready returns to 1.
- In-order drain: allocate tags 0,1,2; resolve 2 then 1 then 0 → writes appear in order 0,1,2 on consecutive cycles after tag 0 resolves.
- Mispredict: history 4'b0000; allocate T(tag0), T(tag1), T(tag2); resolve tag1 not-taken → mispredict=1, rd_bhr=4'b0010, tags 2+ are invalid, next pred_tag=2.
- Simultaneous: a same-cycle mispredict resolve and pred_valid → the allocation is dropped and the BHR equals the repaired value.
- Macro off: allocate T,T → rd_bhr stays 0 until a pop of a taken branch, then 4'b0001.

Source files
------------

// File: rtl/branch_history_queue_pkg.sv
// Shared types for the branch history queue: entry record, tag type, history helpers.
// Table and queue sizes default from BRANCH_HISTORY_TABLE_SIZE / BHQ_QUEUE_DEPTH.
`ifndef BRANCH_HISTORY_TABLE_SIZE
`define BRANCH_HISTORY_TABLE_SIZE 16
`endif
`ifndef BHQ_QUEUE_DEPTH
`define BHQ_QUEUE_DEPTH 8
`endif

package branch_history_queue_pkg;

    localparam int DEPTH = `BRANCH_HISTORY_TABLE_SIZE;
    localparam int BHR_W = $clog2(DEPTH);
    localparam int ADDR_W = 32;
    localparam int QUEUE_DEPTH_DEF = `BHQ_QUEUE_DEPTH;

    typedef logic [$clog2(QUEUE_DEPTH_DEF)-1:0] BHQ_TAG;
    typedef logic [BHR_W-1:0] bhr_t;

    typedef struct packed {
        logic              valid;
        logic              resolved;
        logic [ADDR_W-1:0] pc;
        bhr_t              bhr;
        logic              pred_taken;
        logic              actual_taken;
    } BHQ_ENTRY;

    function automatic bhr_t bhr_shift(bhr_t h, logic t);
        return {h[BHR_W-2:0], t};
    endfunction

endpackage

// File: rtl/branch_history_queue_if.sv
// Fetch / branch-unit / predictor-write bundle of the branch history queue.
// master drives predictions and resolves; slave is the queue itself.
interface branch_history_queue_if #(
    parameter int ADDR_W = 32,
    parameter int BHR_W  = 4,
    parameter int TAG_W  = 3
);

    logic              pred_valid;
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_taken;
    logic              pred_ready;
    logic [TAG_W-1:0]  pred_tag;
    logic [BHR_W-1:0]  rd_bhr;
    logic              resolve_valid;
    logic [TAG_W-1:0]  resolve_tag;
    logic              resolve_taken;
    logic              mispredict;
    logic              wr_en;
    logic              wr_taken;
    logic [ADDR_W-1:0] wr_pc;
    logic [BHR_W-1:0]  wr_bhr;

    modport master (
        output pred_valid, pred_pc, pred_taken,
        output resolve_valid, resolve_tag, resolve_taken,
        input  pred_ready, pred_tag, rd_bhr, mispredict,
        input  wr_en, wr_taken, wr_pc, wr_bhr
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken,
        input  resolve_valid, resolve_tag, resolve_taken,
        output pred_ready, pred_tag, rd_bhr, mispredict,
        output wr_en, wr_taken, wr_pc, wr_bhr
    );

endinterface

// File: rtl/branch_history_queue.sv
// In-flight branch queue: global history, mispredict repair, in-order training.
// BHQ_SPEC_HISTORY_EN selects speculative history; default is committed history.
module branch_history_queue
    import branch_history_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input logic clk,
    input logic rst_n,
    branch_history_queue_if.slave bus
);

    localparam int TAG_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = TAG_W + 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [CNT_W-1:0] cnt_t;

    BHQ_ENTRY q [QUEUE_DEPTH];
    tag_t head;
    tag_t tail;
    cnt_t count;
    bhr_t bhr;

    logic hit;
    logic mis;
    logic pop;
    logic alloc;
    tag_t rt_off;
    logic [QUEUE_DEPTH-1:0] squash;

    assign bus.pred_ready = count < cnt_t'(QUEUE_DEPTH);
    assign bus.pred_tag   = tail;
    assign bus.rd_bhr     = bhr;

    assign hit = bus.resolve_valid && q[bus.resolve_tag].valid;
    assign mis = hit &&
        (bus.resolve_taken != q[bus.resolve_tag].pred_taken);
    assign pop   = q[head].valid && q[head].resolved;
    assign alloc = bus.pred_valid && bus.pred_ready && !mis;
    assign rt_off = bus.resolve_tag - head;

    // Age is measured from head; anything younger than the resolver dies.
    always_comb begin
        squash = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            squash[i] = mis && (tag_t'(tag_t'(i) - head) > rt_off);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q[i] <= '0;
            end
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            bhr        <= '0;
            bus.mispredict <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.wr_taken   <= 1'b0;
            bus.wr_pc      <= '0;
            bus.wr_bhr     <= '0;
        end else begin
            if (alloc) begin
                q[tail] <= '{valid: 1'b1, resolved: 1'b0,
                             pc: bus.pred_pc, bhr: bhr,
                             pred_taken: bus.pred_taken,
                             actual_taken: 1'b0};
            end
            if (hit) begin
                q[bus.resolve_tag].resolved     <= 1'b1;
                q[bus.resolve_tag].actual_taken <= bus.resolve_taken;
            end
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (squash[i]) q[i].valid <= 1'b0;
            end
            if (pop) q[head].valid <= 1'b0;

            head <= head + tag_t'(pop);
            if (mis) begin
                tail  <= bus.resolve_tag + tag_t'(1);
                count <= cnt_t'(rt_off) + cnt_t'(1) - cnt_t'(pop);
            end else begin
                tail  <= tail + tag_t'(alloc);
                count <= count + cnt_t'(alloc) - cnt_t'(pop);
            end

`ifdef BHQ_SPEC_HISTORY_EN
            if (mis) begin
                bhr <= bhr_shift(q[bus.resolve_tag].bhr,
                                 bus.resolve_taken);
            end else if (alloc) begin
                bhr <= bhr_shift(bhr, bus.pred_taken);
            end
`else
            if (pop) bhr <= bhr_shift(bhr, q[head].actual_taken);
`endif

            bus.mispredict <= mis;
            bus.wr_en      <= pop;
            if (pop) begin
                bus.wr_taken <= q[head].actual_taken;
                bus.wr_pc    <= q[head].pc;
                bus.wr_bhr   <= q[head].bhr;
            end
        end
    end

endmodule

// File: tb/tb_branch_history_queue.sv
// Scoreboard bench for branch_history_queue (QUEUE_DEPTH=4, 4-bit history).
// Expected history values follow BHQ_SPEC_HISTORY_EN when it is defined.
module tb_branch_history_queue;
    import branch_history_queue_pkg::*;

    localparam int QD = 4;
    localparam int TW = 2;
`ifdef BHQ_SPEC_HISTORY_EN
    localparam bit SPEC = 1'b1;
`else
    localparam bit SPEC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [3:0]  bhr;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    wr_t exp_q[$];

    branch_history_queue_if #(
        .ADDR_W(ADDR_W), .BHR_W(BHR_W), .TAG_W(TW)
    ) bus ();

    branch_history_queue #(.QUEUE_DEPTH(QD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [31:0] pc, logic t, logic [3:0] h);
        exp_q.push_back('{pc: pc, taken: t, bhr: h});
    endtask

    task automatic alloc(logic [31:0] pc, logic t);
        bus.pred_valid = 1'b1;
        bus.pred_pc    = pc;
        bus.pred_taken = t;
        tick();
        bus.pred_valid = 1'b0;
    endtask

    task automatic resolve(logic [1:0] tag, logic t);
        bus.resolve_valid = 1'b1;
        bus.resolve_tag   = tag;
        bus.resolve_taken = t;
        tick();
        bus.resolve_valid = 1'b0;
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    // Every training write is matched against the program-order scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.wr_en) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(exp_q.size()), 1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_pc", bus.wr_pc, e.pc);
                chk("wr_taken", 32'(bus.wr_taken), 32'(e.taken));
                chk("wr_bhr", 32'(bus.wr_bhr), 32'(e.bhr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.pred_valid    = 1'b0;
        bus.pred_pc       = '0;
        bus.pred_taken    = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_tag   = '0;
        bus.resolve_taken = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.pred_ready), 1);
        chk("rst_tag", 32'(bus.pred_tag), 0);
        chk("rst_bhr", 32'(bus.rd_bhr), 0);
        chk("rst_mis", 32'(bus.mispredict), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_taken", 32'(bus.wr_taken), 0);
        chk("rst_wr_pc", bus.wr_pc, 0);
        chk("rst_wr_bhr", 32'(bus.wr_bhr), 0);
        rst_n = 1'b1;

        // first allocation after reset
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h100;
        bus.pred_taken = 1'b1;
        #1;
        chk("alloc0_tag", 32'(bus.pred_tag), 0);
        push(32'h100, 1'b1, 4'h0);
        tick();
        bus.pred_valid = 1'b0;
        chk("alloc0_bhr", 32'(bus.rd_bhr), SPEC ? 1 : 0);

        // fill
        alloc(32'h104, 1'b0);
        push(32'h104, 1'b0, SPEC ? 4'h1 : 4'h0);
        alloc(32'h108, 1'b1);
        push(32'h108, 1'b1, SPEC ? 4'h2 : 4'h0);
        alloc(32'h10c, 1'b0);
        push(32'h10c, 1'b0, SPEC ? 4'h5 : 4'h0);
        chk("full_ready", 32'(bus.pred_ready), 0);
        chk("full_tag", 32'(bus.pred_tag), 0);
        alloc(32'h200, 1'b1);
        chk("fifth_tag", 32'(bus.pred_tag), 0);
        chk("fifth_ready", 32'(bus.pred_ready), 0);
        chk("fifth_bhr", 32'(bus.rd_bhr), SPEC ? 4'b1010 : 4'b0000);

        resolve(2'd0, 1'b1);
        chk("res0_wr_early", 32'(bus.wr_en), 0);
        tick();
        chk("res0_wr_en", 32'(bus.wr_en), 1);
        chk("res0_ready", 32'(bus.pred_ready), 1);
        chk("res0_bhr", 32'(bus.rd_bhr), SPEC ? 4'b1010 : 4'b0001);

        // out-of-order resolve, in-order drain
        resolve(2'd3, 1'b0);
        resolve(2'd2, 1'b1);
        resolve(2'd1, 1'b0);
        drain("drain_fill");
        chk("fill_bhr", 32'(bus.rd_bhr), 4'b1010);
        tick();
        chk("fill_wr_idle", 32'(bus.wr_en), 0);

        // asynchronous reset discards an unresolved branch
        alloc(32'h300, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tag", 32'(bus.pred_tag), 0);
        chk("arst_bhr", 32'(bus.rd_bhr), 0);
        chk("arst_ready", 32'(bus.pred_ready), 1);
        tick();
        rst_n = 1'b1;

        // mispredict repair and squash
        alloc(32'h400, 1'b1);
        push(32'h400, 1'b1, 4'h0);
        alloc(32'h404, 1'b1);
        push(32'h404, 1'b0, SPEC ? 4'h1 : 4'h0);
        alloc(32'h408, 1'b1);
        chk("mp_pre_bhr", 32'(bus.rd_bhr), SPEC ? 4'b0111 : 4'b0000);
        resolve(2'd1, 1'b0);
        chk("mp_pulse", 32'(bus.mispredict), 1);
        chk("mp_bhr", 32'(bus.rd_bhr), SPEC ? 4'b0010 : 4'b0000);
        chk("mp_tag", 32'(bus.pred_tag), 2);
        chk("mp_ready", 32'(bus.pred_ready), 1);
        tick();
        chk("mp_pulse_end", 32'(bus.mispredict), 0);
        resolve(2'd2, 1'b0);
        chk("squashed_ignored", 32'(bus.mispredict), 0);
        chk("squashed_tag", 32'(bus.pred_tag), 2);
        resolve(2'd0, 1'b1);
        drain("drain_mp");
        chk("mp_post_bhr", 32'(bus.rd_bhr), 4'b0010);

        // same-cycle mispredict and allocation
        alloc(32'h500, 1'b0);
        push(32'h500, 1'b1, 4'b0010);
        chk("sim_pre_bhr", 32'(bus.rd_bhr), SPEC ? 4'b0100 : 4'b0010);
        bus.pred_valid    = 1'b1;
        bus.pred_pc       = 32'h600;
        bus.pred_taken    = 1'b1;
        bus.resolve_valid = 1'b1;
        bus.resolve_tag   = 2'd2;
        bus.resolve_taken = 1'b1;
        tick();
        bus.pred_valid    = 1'b0;
        bus.resolve_valid = 1'b0;
        chk("sim_mis", 32'(bus.mispredict), 1);
        chk("sim_tag", 32'(bus.pred_tag), 3);
        chk("sim_bhr", 32'(bus.rd_bhr), SPEC ? 4'b0101 : 4'b0010);
        tick();
        chk("sim_wr_en", 32'(bus.wr_en), 1);
        chk("sim_pop_bhr", 32'(bus.rd_bhr), 4'b0101);
        drain("drain_sim");
        tick();
        chk("final_wr_idle", 32'(bus.wr_en), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
